ps2_kbd_fifo_io: RTL and testbench
==================================

Name: ps2_kbd_fifo_io

Overview:
Next-generation PS/2 keyboard I/O adapter for the CPU's memory-mapped I/O space, running on a single clock domain. Contains its own PS/2 frame receiver, which performs synchronisation, falling-edge sampling and odd-parity check. Received scan codes go into a parametrised FIFO and are popped by a CPU read strobe. Each popped byte is also shifted into a multi-byte history register so software can detect multi-byte sequences (E0/F0 prefixes).

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries; power of 2, minimum 2
HIST_BYTES, 4, bytes held in key_hist; minimum 1
IDLE_CODE, 8'hAA, value driven on key when no valid read is in progress
TIMEOUT_CYCLES, 5000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  synchronous active-low reset
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
rd  in  1  CPU read strobe; pops one byte when ready=1
clr_err  in  1  clears the sticky overflow and frame_err flags
key  out  8  FIFO head when rd&&ready, else IDLE_CODE (combinational)
key_hist  out  8*HIST_BYTES  popped-byte history; newest byte in [7:0]
ready  out  1  FIFO non-empty
count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a complete valid frame was dropped because the FIFO was full
frame_err  out  1  sticky: bad start, parity or stop bit seen

Behaviour:
- Reset (resetn=0 at a clk edge): FIFO emptied (count=0, ready=0), key_hist=0, overflow=0, frame_err=0, receiver in IDLE, synchroniser flops set to 1. key=IDLE_CODE while reset is held. Reset mid-frame discards the partial frame.
- Synchroniser: 2 flops each on ps2_clk and ps2_data, plus one delayed copy of synced clock. fall = prev_clk & ~sync_clk. Pin-to-fall latency is 2-3 clk cycles.
- Receiver FSM, advancing only on fall:
  - IDLE: data=0 -> DATA with bitcnt=0; data=1 -> stay in IDLE (spurious edge, no error).
  - DATA: shift data in LSB-first; after 8 bits -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: always return to IDLE. Frame is valid if the stop bit is 1 and the odd parity over the 8 data bits plus parity bit holds.
    - Valid frame: push byte.
    - Invalid frame: set frame_err; do not push.
- Push timing: push occurs at the end of the cycle in which the stop-bit fall is seen; ready=1 on the next cycle.
- Pop: occurs when rd && ready at the clk edge. key shows the head combinationally during that cycle. key_hist <= {key_hist[8*HIST_BYTES-9:0], head} at the same edge. rd when empty: no state change, key=IDLE_CODE.
- Full FIFO:
  - Push with no pop: byte is dropped, overflow set, count stays at FIFO_DEPTH.
  - Push with a simultaneous pop: both take effect, count unchanged, no overflow.
- Empty FIFO with a simultaneous push and rd: no pop (ready=0 that cycle); the byte is pushed.
- Pointers wrap modulo FIFO_DEPTH. count is tracked separately so full and empty are unambiguous.
- clr_err=1 clears both sticky flags. If a new error occurs in the same cycle as clr_err, the set wins.

Optional Feature:
PS2_RX_TIMEOUT_EN
- Defined: a timeout counter resets on every fall and increments while the FSM is not in IDLE. On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE and the partial frame is discarded. No flag is set. This resynchronises the receiver after glitches or device hot-plug.
- Undefined: no counter. A partial frame waits indefinitely for further edges.

Decomposition:
- Shared package ps2_pkg holds:
  - receiver state encoding (RX_IDLE, RX_DATA, RX_PARITY, RX_STOP)
  - PS2_FRAME_BITS=11
  - default IDLE_CODE 8'hAA
  - scan-code constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0, for software and bench use
- One natural sub-module: ps2_rx, containing the synchroniser, FSM and parity check. Its outputs are rx_byte, rx_valid (single-cycle pulse) and rx_err (single-cycle pulse). FIFO and history logic stay in the top level.

Test Plan:
- Send a frame for 0x1C with correct odd parity, then pulse rd once -> ready rises the cycle after the stop fall; key=8'h1C during rd; count 1->0; key_hist[7:0]=8'h1C.
- Send 0x1C with the parity bit inverted -> frame_err=1, count stays 0. Pulse clr_err -> frame_err=0.
- FIFO_DEPTH=8: send 9 valid frames 0x01..0x09 with no reads -> count=8, overflow=1. Reads return 0x01..0x08; key_hist ends as 32'h05060708.
- Fill FIFO to 8, then align a 9th stop-bit fall with an rd pulse -> no overflow, count stays 8, the new byte is last out.
- Assert resetn=0 after 5 bits of a frame, release, then send 0x5A -> only 0x5A is received, no frame_err.
- With PS2_RX_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 4 bits, idle 150 cycles, then send full 0x29 -> 0x29 received, frame_err=0. Without the macro -> frame_err=1 and 0x29 is not received.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: receiver states, frame
// length, default idle code and common scan-code prefixes.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_IDLE_CODE = 8'hAA;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchroniser, falling-edge FSM, parity.
// Optional PS2_RX_TIMEOUT_EN abandons stalled partial frames.
`timescale 1ns/1ps
module ps2_rx
  import ps2_pkg::*;
`ifdef PS2_RX_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 5000
)
`endif
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;
  logic frame_ok;
  logic par;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  rx_state_t state;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo;
`endif

  assign fall = clk_prev & ~clk_s2;
  assign frame_ok = dat_s2 & odd_ok(shreg, par);
  assign rx_byte = shreg;
  assign rx_valid = fall && state == RX_STOP && frame_ok;
  assign rx_err = fall && state == RX_STOP && !frame_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      state <= RX_IDLE;
      bitcnt <= '0;
      shreg <= '0;
      par <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo <= '0;
`endif
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      if (fall) begin
        unique case (state)
          RX_IDLE: begin
            if (!dat_s2) begin
              state <= RX_DATA;
              bitcnt <= '0;
            end
          end
          RX_DATA: begin
            shreg <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7)
              state <= RX_PARITY;
          end
          RX_PARITY: begin
            par <= dat_s2;
            state <= RX_STOP;
          end
          RX_STOP: state <= RX_IDLE;
          default: state <= RX_IDLE;
        endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      // a stalled partial frame is dropped silently
      if (fall || state == RX_IDLE)
        tmo <= '0;
      else
        tmo <= tmo + 1'b1;
      if (!fall && state != RX_IDLE && tmo == TMO_LAST)
        state <= RX_IDLE;
`endif
    end
  end

endmodule

// File: rtl/ps2_kbd_fifo_io.sv
// PS/2 keyboard MMIO adapter: receiver, scan-code FIFO, pop history.
// Build option: PS2_RX_TIMEOUT_EN enables partial-frame timeout.
`timescale 1ns/1ps
module ps2_kbd_fifo_io
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int HIST_BYTES = 4,
  parameter logic [7:0] IDLE_CODE = PS2_IDLE_CODE
`ifdef PS2_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 5000
`endif
) (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk,
  input  logic ps2_data,
  input  logic rd,
  input  logic clr_err,
  output logic [7:0] key,
  output logic [8*HIST_BYTES-1:0] key_hist,
  output logic ready,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic overflow,
  output logic frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic rx_valid, rx_err;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] head;
  logic full, pop, push;

  ps2_rx
`ifdef PS2_RX_TIMEOUT_EN
    #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
  u_rx (
    .clk(clk),
    .resetn(resetn),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .rx_err(rx_err)
  );

  assign full = count == FULL_CNT;
  assign ready = count != '0;
  assign pop = rd && ready;
  // a full FIFO still accepts a byte when a pop frees a slot
  assign push = rx_valid && (!full || pop);
  assign head = mem[rd_ptr];
  assign key = (resetn && pop) ? head : IDLE_CODE;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10: count <= count + (AW+1)'(1);
        2'b01: count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (rx_valid && full && !pop)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
      if (rx_err)
        frame_err <= 1'b1;
      else if (clr_err)
        frame_err <= 1'b0;
    end
  end

  generate
    if (HIST_BYTES == 1) begin : g_hist1
      always_ff @(posedge clk) begin
        if (!resetn)
          key_hist <= '0;
        else if (pop)
          key_hist <= head;
      end
    end else begin : g_histn
      always_ff @(posedge clk) begin
        if (!resetn)
          key_hist <= '0;
        else if (pop)
          key_hist <= {key_hist[8*HIST_BYTES-9:0], head};
      end
    end
  endgenerate

endmodule

// File: tb/tb_ps2_kbd_fifo_io.sv
// Self-checking bench for ps2_kbd_fifo_io with a byte scoreboard.
// Honours PS2_RX_TIMEOUT_EN (TIMEOUT_CYCLES=100 when defined).
`timescale 1ns/1ps
module tb_ps2_kbd_fifo_io;
  import ps2_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic rd = 1'b0;
  logic clr_err = 1'b0;
  logic [7:0] key;
  logic [31:0] key_hist;
  logic ready;
  logic [3:0] count;
  logic overflow;
  logic frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [31:0] hist_m = '0;

  always #5 clk = ~clk;

  ps2_kbd_fifo_io #(
    .FIFO_DEPTH(DEPTH),
    .HIST_BYTES(4),
    .IDLE_CODE(8'hAA)
`ifdef PS2_RX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .rd(rd),
    .clr_err(clr_err),
    .key(key),
    .key_hist(key_hist),
    .ready(ready),
    .count(count),
    .overflow(overflow),
    .frame_err(frame_err)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  function automatic logic [10:0] mk(
    input logic [7:0] b,
    input bit bad
  );
    logic p;
    p = (~^b) ^ bad;
    return {1'b1, p, b, 1'b0};
  endfunction

  // mode 1: check ready edge at stop; mode 2: rd aligned with stop fall
  task automatic send_bits(
    input logic [10:0] f,
    input int n,
    input int mode
  );
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0) begin
          n_bad++;
          $display("FAIL ready_early: got %b required 0", ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin
          n_bad++;
          $display("FAIL ready_rise: got %b required 1", ready);
        end
      end else if (i == 10 && mode == 2) begin
        repeat (2) @(negedge clk);
        rd = 1'b1;
        #1;
        e = exp_q.pop_front();
        hist_m = {hist_m[23:0], e};
        n_cmp++;
        if (key !== e) begin
          n_bad++;
          $display("FAIL key_at_stop: got %h required %h", key, e);
        end
        @(negedge clk);
        rd = 1'b0;
      end else begin
        repeat (3) @(negedge clk);
      end
      repeat (7) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(
    input logic [7:0] b,
    input bit bad,
    input int mode
  );
    send_bits(mk(b, bad), PS2_FRAME_BITS, mode);
    if (!bad && (mode == 2 || exp_q.size() < DEPTH))
      exp_q.push_back(b);
  endtask

  task automatic do_read();
    logic [7:0] e;
    bit have;
    @(negedge clk);
    rd = 1'b1;
    #1;
    have = exp_q.size() != 0;
    e = have ? exp_q[0] : PS2_IDLE_CODE;
    n_cmp++;
    if (key !== e) begin
      n_bad++;
      $display("FAIL read_key: got %h required %h", key, e);
    end
    if (have) begin
      void'(exp_q.pop_front());
      hist_m = {hist_m[23:0], e};
    end
    @(negedge clk);
    rd = 1'b0;
    #1;
    n_cmp++;
    if (key_hist !== hist_m || count !== 4'(exp_q.size())) begin
      n_bad++;
      $display("FAIL read_state: got hist %h cnt %0d required %h %0d",
               key_hist, count, hist_m, exp_q.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({count, ready, overflow, frame_err} !== 7'b0 ||
        key !== 8'hAA || key_hist !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: got cnt %0d rdy %b key %h hist %h",
               count, ready, key, key_hist);
    end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 1'b0, 1);
    n_cmp++;
    if (count !== 4'd1) begin
      n_bad++;
      $display("FAIL basic_count: got %0d required 1", count);
    end
    do_read();
    n_cmp++;
    if (key_hist[7:0] !== 8'h1C) begin
      n_bad++;
      $display("FAIL basic_hist: got %h required 1c", key_hist[7:0]);
    end
    do_read();
  endtask

  task automatic test_parity_err();
    send_frame(8'h1C, 1'b1, 0);
    n_cmp++;
    if (frame_err !== 1'b1 || count !== 4'd0) begin
      n_bad++;
      $display("FAIL parity_err: got err %b cnt %0d required 1 0",
               frame_err, count);
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_err: got %b required 0", frame_err);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++)
      send_frame(8'(i), 1'b0, 0);
    n_cmp++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow: got cnt %0d ovf %b required 8 1",
               count, overflow);
    end
    for (int i = 0; i < 8; i++)
      do_read();
    n_cmp++;
    if (key_hist !== 32'h05060708 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_hist: got %h rdy %b required 05060708 0",
               key_hist, ready);
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clr: got %b required 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 8; i++)
      send_frame(8'h10 + 8'(i), 1'b0, 0);
    send_frame(8'h18, 1'b0, 2);
    n_cmp++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pop: got cnt %0d ovf %b required 8 0",
               count, overflow);
    end
    for (int i = 0; i < 8; i++)
      do_read();
    n_cmp++;
    if (key_hist[7:0] !== 8'h18) begin
      n_bad++;
      $display("FAIL full_pop_last: got %h required 18", key_hist[7:0]);
    end
  endtask

  task automatic test_reset_midframe();
    send_bits(mk(8'h33, 1'b0), 5, 0);
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    hist_m = '0;
    repeat (3) @(negedge clk);
    send_frame(8'h5A, 1'b0, 0);
    n_cmp++;
    if (count !== 4'd1 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset: got cnt %0d err %b required 1 0",
               count, frame_err);
    end
    do_read();
  endtask

  task automatic test_timeout();
    send_bits(mk(8'h00, 1'b0), 4, 0);
    repeat (150) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    send_frame(8'h29, 1'b0, 0);
    n_cmp++;
    if (frame_err !== 1'b0 || count !== 4'd1) begin
      n_bad++;
      $display("FAIL timeout: got err %b cnt %0d required 0 1",
               frame_err, count);
    end
    do_read();
`else
    send_bits(mk(8'h29, 1'b0), PS2_FRAME_BITS, 0);
    n_cmp++;
    if (frame_err !== 1'b1 || count !== 4'd0) begin
      n_bad++;
      $display("FAIL no_timeout: got err %b cnt %0d required 1 0",
               frame_err, count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
